// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Clocks per brightness sub-slot.
  function automatic int unsigned calc_div_sub(input int unsigned clk_hz,
                                               input int unsigned scan_hz,
                                               input int unsigned bright_w);
    return clk_hz / (scan_hz * (32'd1 << bright_w));
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    return 8'(1) << sel;
  endfunction

  // Maps an active-high pattern onto the pin polarity.
  function automatic logic [7:0] apply_pol(input logic [7:0] val, input logic active_low);
    return active_low ? ~val : val;
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running divider producing one sub-slot tick every DIV_SUB clocks.
module seg7_prescaler #(
  parameter int unsigned DIV_SUB = 4,
  parameter int unsigned PCNT_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [PCNT_W-1:0] o_pcnt,
  output logic              o_sub_tick_c
);

  logic [PCNT_W-1:0] r_pcnt;

  assign o_pcnt       = r_pcnt;
  assign o_sub_tick_c = (r_pcnt == PCNT_W'(DIV_SUB - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)             r_pcnt <= '0;
    else if (o_sub_tick_c) r_pcnt <= '0;
    else                   r_pcnt <= r_pcnt + PCNT_W'(1);
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed N-digit 7-segment driver with PWM brightness, per-digit
// blanking/blink/dp and an anti-ghost dark gap at the start of each slot.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SCAN_HZ        = 400,
  parameter int unsigned BRIGHT_W       = 3,
  parameter int unsigned BLINK_FRAMES   = 50,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_50M,
  input  logic                    cr,
  input  logic [7*NUM_DIGITS-1:0] hex_bus,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned DIV_SUB = calc_div_sub(CLK_HZ, SCAN_HZ, BRIGHT_W);
  localparam int unsigned PCNT_W  = (DIV_SUB > 1) ? $clog2(DIV_SUB) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FCNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = NUM_DIGITS'(apply_pol(8'h00, AN_ACTIVE_LOW));
  localparam logic [6:0]            SEG_IDLE = 7'(apply_pol(8'(SEG_OFF), SEG_ACTIVE_LOW));
  localparam logic                  DP_IDLE  = 1'(apply_pol(8'h00, SEG_ACTIVE_LOW));

  if (DIV_SUB < 2) begin : g_bad_div
    $error("seg7_scan_mux: CLK_HZ/(SCAN_HZ*2^BRIGHT_W) must be at least 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_mux: NUM_DIGITS must be in 1..8");
  end

  logic [PCNT_W-1:0]   w_pcnt;
  logic                w_sub_tick;
  logic [BRIGHT_W-1:0] r_ss;
  logic [IDX_W-1:0]    r_idx;
  logic [FCNT_W-1:0]   r_fcnt;
  logic                r_blink_off;
  logic [6:0]          w_dig_seg [NUM_DIGITS];
  logic                w_first;
  logic                w_lit;

  seg7_prescaler #(
    .DIV_SUB (DIV_SUB),
    .PCNT_W  (PCNT_W)
  ) u_prescaler (
    .i_clk        (clk_50M),
    .i_rst        (cr),
    .o_pcnt       (w_pcnt),
    .o_sub_tick_c (w_sub_tick)
  );

  // Sub-slot, digit and blink-frame counters cascade off the sub-slot tick.
  always_ff @(posedge clk_50M or posedge cr) begin
    if (cr) begin
      r_ss        <= '0;
      r_idx       <= '0;
      r_fcnt      <= '0;
      r_blink_off <= 1'b0;
    end else if (w_sub_tick) begin
      r_ss <= r_ss + BRIGHT_W'(1);
      if (r_ss == '1) begin
        if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
          r_idx <= '0;
          if (r_fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
            r_fcnt      <= '0;
            r_blink_off <= ~r_blink_off;
          end else begin
            r_fcnt <= r_fcnt + FCNT_W'(1);
          end
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_dig_seg[i] = hex_bus[7*i +: 7];
    end
  end

  // The first clock of every slot is forced dark so the anode switch never ghosts.
  always_comb begin
    w_first = (w_pcnt == '0) && (r_ss == '0);
    w_lit   = (r_ss <= brightness) && !blank[r_idx] &&
              !(blink_en[r_idx] && r_blink_off) && !w_first;
  end

  always_ff @(posedge clk_50M or posedge cr) begin
    if (cr) begin
      an          <= AN_OFF;
      seg         <= SEG_IDLE;
      dp          <= DP_IDLE;
      frame_start <= 1'b0;
    end else begin
      an          <= NUM_DIGITS'(apply_pol(w_lit ? onehot8(3'(r_idx)) : 8'h00, AN_ACTIVE_LOW));
      seg         <= 7'(apply_pol(8'(w_lit ? w_dig_seg[r_idx] : SEG_OFF), SEG_ACTIVE_LOW));
      dp          <= 1'(apply_pol(8'(w_lit & dp_in[r_idx]), SEG_ACTIVE_LOW));
      frame_start <= w_first && (r_idx == '0);
    end
  end

endmodule
